pe_mac_sat: RTL and testbench

PE_MAC_SAT -- requirements
Module: pe_mac_sat

---
 rtl/pe_pkg.sv | 12 +
 rtl/pe_sat_add.sv | 36 +++
 rtl/pe_mac_sat.sv | 107 ++++++++++
 tb/tb_pe_mac_sat.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared FSM state encoding for the pe_mac_sat processing element.
package pe_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_sat_add.sv
// Accumulator adder with overflow detection; saturates on overflow when
// PE_SATURATE_EN is defined, otherwise wraps modulo 2^BUS_WIDTH.
module pe_sat_add #(
  parameter int BUS_WIDTH   = 32,
  parameter int SIGNED_MODE = 0
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] sum,
  output logic                 overflow
);

  logic [BUS_WIDTH:0] raw;

  // Signed overflow is carry-into-MSB xor carry-out, both recovered from raw.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = raw[BUS_WIDTH-1:0];
    if (SIGNED_MODE != 0) begin
      overflow = raw[BUS_WIDTH] ^ raw[BUS_WIDTH-1] ^ a[BUS_WIDTH-1] ^ b[BUS_WIDTH-1];
    end else begin
      overflow = raw[BUS_WIDTH];
    end
`ifdef PE_SATURATE_EN
    if (overflow) begin
      if (SIGNED_MODE != 0) begin
        sum = a[BUS_WIDTH-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                             : {1'b0, {(BUS_WIDTH-1){1'b1}}};
      end else begin
        sum = '1;
      end
    end
`endif
  end

endmodule

// File: rtl/pe_mac_sat.sv
// Systolic multiply-accumulate processing element with sticky overflow flag.
// Optional clamping of the accumulator is enabled by defining PE_SATURATE_EN.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_operation_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_A_i,
  input  logic [DATA_WIDTH-1:0] data_B_i,
  output logic [DATA_WIDTH-1:0] data_A_o,
  output logic [DATA_WIDTH-1:0] data_B_o,
  output logic                  valid_o,
  output logic [BUS_WIDTH-1:0]  accum_o,
  output logic                  overflow_o,
  output logic                  done_o
);

  localparam int PW = 2 * DATA_WIDTH;

  pe_state_e            state_q, state_d;
  logic [PW-1:0]        prod;
  logic [BUS_WIDTH-1:0] prod_ext;
  logic [BUS_WIDTH-1:0] accum_q;
  logic [BUS_WIDTH-1:0] sum;
  logic                 add_ovf;
  logic                 ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_operation_i) state_d = ACCUM;
      ACCUM:   if (!start_operation_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Product is formed at full 2*DATA_WIDTH precision, then widened per signedness.
  always_comb begin
    if (SIGNED_MODE != 0) begin
      prod     = $unsigned(PW'($signed(data_A_i)) * PW'($signed(data_B_i)));
      prod_ext = $unsigned(BUS_WIDTH'($signed(prod)));
    end else begin
      prod     = PW'(data_A_i) * PW'(data_B_i);
      prod_ext = BUS_WIDTH'(prod);
    end
  end

  pe_sat_add #(
    .BUS_WIDTH  (BUS_WIDTH),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_sat_add (
    .a       (accum_q),
    .b       (prod_ext),
    .sum     (sum),
    .overflow(add_ovf)
  );

  // Clear wins over a coincident MAC; operands are only taken while the window stays open.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      accum_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      accum_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && start_operation_i) begin
      accum_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == ACCUM && start_operation_i && valid_i) begin
      accum_q <= sum;
      ovf_q   <= ovf_q | add_ovf;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_A_o <= '0;
      data_B_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      data_A_o <= data_A_i;
      data_B_o <= data_B_i;
      valid_o  <= valid_i;
    end
  end

  assign accum_o    = accum_q;
  assign overflow_o = ovf_q;
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_pe_mac_sat.sv
// Self-checking bench for pe_mac_sat: table-driven scoreboard on the default
// configuration plus directed signed/overflow sequences on narrower instances.
module tb_pe_mac_sat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clr;
  logic       vld;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic [7:0]  d_a_o, d_b_o, s_a_o, s_b_o, u16_a_o, u16_b_o, s16_a_o, s16_b_o;
  logic        d_vo, s_vo, u16_vo, s16_vo;
  logic [31:0] d_acc, s_acc;
  logic [15:0] u16_acc, s16_acc;
  logic        d_ovf, s_ovf, u16_ovf, s16_ovf;
  logic        d_done, s_done, u16_done, s16_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst_n, start, clr, vld;
    logic [7:0]  a, b;
    logic [31:0] exp_acc;
    logic        exp_ovf, exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] acc;
    logic        ovf, done, vo;
    logic [7:0]  a_o, b_o;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[24];

  always #5 clk = ~clk;

  pe_mac_sat u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_operation_i(start), .clear_i(clr), .valid_i(vld),
    .data_A_i(a_in), .data_B_i(b_in), .data_A_o(d_a_o), .data_B_o(d_b_o), .valid_o(d_vo),
    .accum_o(d_acc), .overflow_o(d_ovf), .done_o(d_done));

  pe_mac_sat #(.SIGNED_MODE(1)) u_sgn (
    .clk_i(clk), .rst_n_i(rst_n), .start_operation_i(start), .clear_i(clr), .valid_i(vld),
    .data_A_i(a_in), .data_B_i(b_in), .data_A_o(s_a_o), .data_B_o(s_b_o), .valid_o(s_vo),
    .accum_o(s_acc), .overflow_o(s_ovf), .done_o(s_done));

  pe_mac_sat #(.BUS_WIDTH(16)) u_u16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_operation_i(start), .clear_i(clr), .valid_i(vld),
    .data_A_i(a_in), .data_B_i(b_in), .data_A_o(u16_a_o), .data_B_o(u16_b_o), .valid_o(u16_vo),
    .accum_o(u16_acc), .overflow_o(u16_ovf), .done_o(u16_done));

  pe_mac_sat #(.BUS_WIDTH(16), .SIGNED_MODE(1)) u_s16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_operation_i(start), .clear_i(clr), .valid_i(vld),
    .data_A_i(a_in), .data_B_i(b_in), .data_A_o(s16_a_o), .data_B_o(s16_b_o), .valid_o(s16_vo),
    .accum_o(s16_acc), .overflow_o(s16_ovf), .done_o(s16_done));

  function automatic vec_t mkVec(input logic r, input logic s, input logic c, input logic v,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [31:0] acc, input logic ovf, input logic done);
    vec_t t;
    t.rst_n = r; t.start = s; t.clr = c; t.vld = v; t.a = a; t.b = b;
    t.exp_acc = acc; t.exp_ovf = ovf; t.exp_done = done;
    return t;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and return just after the next rising edge.
  task automatic step(input logic r, input logic s, input logic c, input logic v,
                      input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst_n = r; start = s; clr = c; vld = v; a_in = a; b_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t t);
    exp_t e;
    e.acc  = t.exp_acc;
    e.ovf  = t.exp_ovf;
    e.done = t.exp_done;
    e.vo   = t.rst_n ? t.vld : 1'b0;
    e.a_o  = t.rst_n ? t.a : 8'h00;
    e.b_o  = t.rst_n ? t.b : 8'h00;
    sb_q.push_back(e);
    step(t.rst_n, t.start, t.clr, t.vld, t.a, t.b);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty[%0d]: got 0 entries, expected 1", idx);
      return;
    end
    n_checks--;
    e = sb_q.pop_front();
    checkValue($sformatf("accum[%0d]", idx), d_acc, e.acc);
    checkValue($sformatf("overflow[%0d]", idx), 32'(d_ovf), 32'(e.ovf));
    checkValue($sformatf("done[%0d]", idx), 32'(d_done), 32'(e.done));
    checkValue($sformatf("valid_o[%0d]", idx), 32'(d_vo), 32'(e.vo));
    checkValue($sformatf("data_A_o[%0d]", idx), 32'(d_a_o), 32'(e.a_o));
    checkValue($sformatf("data_B_o[%0d]", idx), 32'(d_b_o), 32'(e.b_o));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; vld = 1'b0; a_in = '0; b_in = '0;

    //                  rst  st   clr  vld  A      B      accum  ovf  done
    vecs[0]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd3, 32'd0,  1'b0, 1'b0);
    vecs[1]  = mkVec(1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 8'd4, 32'd0,  1'b0, 1'b0);
    vecs[2]  = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b0);
    vecs[3]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd3, 32'd21, 1'b0, 1'b0);
    vecs[4]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 32'd23, 1'b0, 1'b0);
    vecs[5]  = mkVec(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd5, 32'd23, 1'b0, 1'b1);
    vecs[6]  = mkVec(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 32'd23, 1'b0, 1'b0);
    vecs[7]  = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'd23, 1'b0, 1'b0);
    vecs[8]  = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b0);
    vecs[9]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd3, 32'd21, 1'b0, 1'b0);
    vecs[10] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 32'd23, 1'b0, 1'b0);
    vecs[11] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 8'd5, 32'd0,  1'b0, 1'b0);
    vecs[12] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 32'd1,  1'b0, 1'b0);
    vecs[13] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd3, 32'd22, 1'b0, 1'b0);
    vecs[14] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 8'd3, 32'd0,  1'b0, 1'b0);
    vecs[15] = mkVec(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd3, 32'd0,  1'b0, 1'b0);
    vecs[16] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b0);
    vecs[17] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 8'd4, 32'd16, 1'b0, 1'b0);
    vecs[18] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'd16, 1'b0, 1'b1);
    vecs[19] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd16, 1'b0, 1'b0);
    vecs[20] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b0);
    vecs[21] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd3, 32'd9,  1'b0, 1'b0);
    vecs[22] = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b1);
    vecs[23] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0,  1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Signed operands: (-3)*4 + 2*1 = -10.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFD, 8'h04);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkValue("sgn_accum", s_acc, 32'hFFFF_FFF6);
    checkValue("sgn_overflow", 32'(s_ovf), 32'd0);
    checkValue("sgn_done", 32'(s_done), 32'd1);
    checkValue("uns_accum_same_operands", d_acc, 32'h0000_03F6);

    // Unsigned 16-bit overflow: 255*255 twice.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef PE_SATURATE_EN
    checkValue("u16_accum_ovf", 32'(u16_acc), 32'd65535);
`else
    checkValue("u16_accum_ovf", 32'(u16_acc), 32'd64514);
`endif
    checkValue("u16_overflow", 32'(u16_ovf), 32'd1);
    checkValue("s16_accum_minus1_sq", 32'(s16_acc), 32'd2);
    checkValue("s16_overflow_none", 32'(s16_ovf), 32'd0);
    checkValue("dut32_accum_no_ovf", d_acc, 32'd130050);
    checkValue("dut32_overflow_none", 32'(d_ovf), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkValue("u16_accum_cleared", 32'(u16_acc), 32'd0);
    checkValue("u16_overflow_cleared", 32'(u16_ovf), 32'd0);

    // Signed 16-bit positive overflow, then a further add to show stickiness.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80);
`ifdef PE_SATURATE_EN
    checkValue("s16_accum_pos_ovf", 32'(s16_acc), 32'h7FFF);
`else
    checkValue("s16_accum_pos_ovf", 32'(s16_acc), 32'h8000);
`endif
    checkValue("s16_overflow_pos", 32'(s16_ovf), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01);
`ifdef PE_SATURATE_EN
    checkValue("s16_accum_after_ovf", 32'(s16_acc), 32'h7FFF);
`else
    checkValue("s16_accum_after_ovf", 32'(s16_acc), 32'h8001);
`endif
    checkValue("s16_overflow_sticky", 32'(s16_ovf), 32'd1);
    checkValue("u16_accum_no_ovf", 32'(u16_acc), 32'h8001);
    checkValue("u16_overflow_none", 32'(u16_ovf), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkValue("s16_overflow_held_idle", 32'(s16_ovf), 32'd1);

    // Restarting the window drops the flag; then signed negative overflow.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkValue("s16_overflow_restart", 32'(s16_ovf), 32'd0);
    checkValue("s16_accum_restart", 32'(s16_acc), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    checkValue("s16_overflow_not_yet", 32'(s16_ovf), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
`ifdef PE_SATURATE_EN
    checkValue("s16_accum_neg_ovf", 32'(s16_acc), 32'h8000);
`else
    checkValue("s16_accum_neg_ovf", 32'(s16_acc), 32'h4180);
`endif
    checkValue("s16_overflow_neg", 32'(s16_ovf), 32'd1);
    checkValue("u16_accum_three", 32'(u16_acc), 32'hBE80);

    // Reset while accumulating forces everything to zero.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 8'h03);
    checkValue("rst_s16_accum", 32'(s16_acc), 32'd0);
    checkValue("rst_s16_overflow", 32'(s16_ovf), 32'd0);
    checkValue("rst_s16_valid_o", 32'(s16_vo), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
